// File: rtl/weight_bank_loader_layer_1.sv
// Streams NUM*DEPTH weight words, bank-major, into NUM parallel weight banks and
// exposes every bank's word at a shared address through a zero-latency read port.
module weight_bank_loader_layer_1 #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 5,
    parameter int NUM   = 64,
    parameter int DEPTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    input  logic [ADDR-1:0]  address,
    output logic [WIDTH-1:0] rom_out [0:NUM-1],
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int BW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BW-1:0]     bank_cnt;
    logic [ADDR-1:0]   addr_cnt;
    logic              accept;
    logic              last_word;
    logic              addr_wrap;

    logic [WIDTH-1:0]  mem [0:NUM-1][0:(2**ADDR)-1];

    assign s_ready   = (state == LOAD);
    assign busy      = (state == LOAD);
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign accept    = s_valid && s_ready;
    assign addr_wrap = (addr_cnt == ADDR'(DEPTH - 1));
    assign last_word = addr_wrap && (bank_cnt == BW'(NUM - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment first keeps every path covered, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (last_word) begin
                        state_nxt = s_last ? DONE : ERR;
                    end else if (s_last) begin
                        state_nxt = ERR;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_cnt <= '0;
            addr_cnt <= '0;
        end else if (state != LOAD) begin
            if (start) begin
                bank_cnt <= '0;
                addr_cnt <= '0;
            end
        end else if (accept) begin
            if (addr_wrap) begin
                addr_cnt <= '0;
                bank_cnt <= bank_cnt + 1'b1;
            end else begin
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    // NOTE: the weight storage has no reset on purpose; partial loads stay
    // readable after reset and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[bank_cnt][addr_cnt] <= s_data;
        end
    end

    // Asynchronous read: a write landing this cycle is seen only from the next one.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            rom_out[i] = mem[i][address];
        end
    end

endmodule

// File: tb/tb_weight_bank_loader_layer_1.sv
// Directed bench for weight_bank_loader_layer_1: full loads, gapped loads,
// early/missing s_last, mid-load reset and start-during-load.
module tb_weight_bank_loader_layer_1;

    localparam int WIDTH = 16;
    localparam int ADDR  = 5;
    localparam int NUM   = 64;
    localparam int DEPTH = 27;
    localparam int TOTAL = NUM * DEPTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             s_ready;
    logic [ADDR-1:0]  address;
    logic [WIDTH-1:0] rom_out [0:NUM-1];
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    typedef enum int { PAT_P, PAT_Q, PAT_R } pat_t;

    weight_bank_loader_layer_1 #(
        .WIDTH(WIDTH), .ADDR(ADDR), .NUM(NUM), .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .address (address),
        .rom_out (rom_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Expected word value for stream index idx under each data pattern.
    function automatic logic [WIDTH-1:0] pat(input pat_t kind, input int idx);
        case (kind)
            PAT_P:   return WIDTH'((idx / DEPTH) * 32 + (idx % DEPTH));
            PAT_Q:   return WIDTH'(32'h8000 ^ idx);
            default: return WIDTH'(32'h4000 | idx);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] data, input logic last);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 16'hDEAD;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Gap cycles drive s_valid=0 with garbage data and s_last=1: none may be taken.
    task automatic load_range(input pat_t kind, input int first, input int last_idx,
                              input logic final_last, input int max_gap);
        for (int idx = first; idx <= last_idx; idx++) begin
            if (max_gap > 0) begin
                int gap;
                gap = $urandom_range(0, max_gap);
                for (int g = 0; g < gap; g++) begin
                    s_valid = 1'b0;
                    s_last  = 1'b1;
                    s_data  = 16'hBEEF;
                    if (g == 0) check("gap_s_ready", s_ready, 1);
                    tick();
                end
                s_last = 1'b0;
            end
            push(pat(kind, idx), (idx == last_idx) ? final_last : 1'b0);
        end
    endtask

    task automatic read_word(input int bank, input int addr_i, output logic [WIDTH-1:0] val);
        address = ADDR'(addr_i);
        #1;
        val = rom_out[bank];
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        address = '0;

        // Reset state
        repeat (2) tick();
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Start pulse -> LOAD next cycle
        pulse_start();
        check("start_busy", busy, 1);
        check("start_s_ready", s_ready, 1);

        // Gap-free full load, pattern bank*32+addr
        load_range(PAT_P, 0, TOTAL - 2, 1'b0, 0);
        check("pre_last_done", done, 0);
        push(pat(PAT_P, TOTAL - 1), 1'b1);
        check("full_done", done, 1);
        check("full_busy", busy, 0);
        check("full_s_ready", s_ready, 0);
        read_word(63, 26, v);
        check("full_b63_a26", v, 16'd2042);
        read_word(0, 26, v);
        check("full_b0_a26", v, 16'd26);
        read_word(17, 5, v);
        check("full_b17_a5", v, 16'd549);

        // Early s_last on word index 100 = bank 3 address 19 (100 = 3*27 + 19)
        pulse_start();
        load_range(PAT_Q, 0, 100, 1'b1, 0);
        check("early_err", err, 1);
        check("early_done", done, 0);
        check("early_s_ready", s_ready, 0);
        read_word(3, 19, v);
        check("early_b3_a19", v, pat(PAT_Q, 100));
        read_word(3, 20, v);
        check("early_b3_a20_old", v, 16'd116);
        push(16'h1234, 1'b0);
        push(16'h5678, 1'b1);
        check("err_hold", err, 1);
        read_word(3, 20, v);
        check("err_no_write", v, 16'd116);

        // Final word without s_last -> ERR
        pulse_start();
        check("reload_busy", busy, 1);
        load_range(PAT_Q, 0, TOTAL - 1, 1'b0, 0);
        check("nolast_err", err, 1);
        check("nolast_done", done, 0);
        read_word(63, 26, v);
        check("nolast_b63_a26", v, pat(PAT_Q, TOTAL - 1));

        // Restart from ERR with random gaps, pattern p again: counters must restart at 0
        pulse_start();
        check("restart_busy", busy, 1);
        check("restart_err", err, 0);
        load_range(PAT_P, 0, TOTAL - 1, 1'b1, 5);
        check("gap_done", done, 1);
        for (int a = 0; a < DEPTH; a++) begin
            address = ADDR'(a);
            #1;
            for (int b = 0; b < NUM; b++) begin
                check($sformatf("gap_b%0d_a%0d", b, a), rom_out[b], pat(PAT_P, b * DEPTH + a));
            end
        end

        // Start during LOAD is ignored; reset after 500 words aborts the load
        pulse_start();
        load_range(PAT_R, 0, 249, 1'b0, 0);
        start = 1'b1;
        push(pat(PAT_R, 250), 1'b0);
        start = 1'b0;
        check("start_in_load_busy", busy, 1);
        load_range(PAT_R, 251, 499, 1'b0, 0);
        read_word(0, 0, v);
        check("sil_b0_a0", v, pat(PAT_R, 0));
        read_word(9, 7, v);
        check("sil_b9_a7", v, pat(PAT_R, 250));
        read_word(9, 8, v);
        check("sil_b9_a8", v, pat(PAT_R, 251));
        read_word(18, 13, v);
        check("sil_b18_a13", v, pat(PAT_R, 499));
        read_word(18, 14, v);
        check("sil_b18_a14_old", v, 16'd590);

        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_s_ready", s_ready, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        tick();
        rst = 1'b0;
        tick();
        push(16'h7777, 1'b0);
        check("post_rst_idle", s_ready, 0);
        read_word(0, 0, v);
        check("post_rst_b0_a0", v, pat(PAT_R, 0));
        read_word(18, 13, v);
        check("post_rst_b18_a13", v, pat(PAT_R, 499));
        pulse_start();
        check("post_rst_start_busy", busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
